// File: rtl/uart_hex_loader.sv
// ============================================================================
// Module  : uart_hex_loader
// Purpose : Loads ASCII-hex words from a UART byte stream into memory, echoing
//           every consumed byte and counting protocol errors.
// Rev     : 1.0
// ============================================================================
`default_nettype none

module uart_hex_loader #(
    parameter int WORD_W = 32,
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rx_valid,
    input  logic [7:0]        rx_data,
    output logic              rx_clr,
    input  logic              tx_busy,
    output logic              tx_wr,
    output logic [7:0]        tx_data,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [WORD_W-1:0] mem_wdata,
    output logic [ADDR_W:0]   word_count,
    output logic              full,
    output logic [7:0]        err_count,
    output logic              load_done
);

    localparam int                 NIBBLES   = WORD_W / 4;
    localparam int                 NIB_W     = $clog2(NIBBLES + 1);
    localparam int                 CNT_W     = ADDR_W + 1;
    localparam logic [NIB_W-1:0]   LAST_NIB  = NIB_W'(NIBBLES - 1);
    localparam logic [CNT_W-1:0]   DEPTH_CNT = CNT_W'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WRITE = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [WORD_W-1:0]   acc_q, acc_d;
    logic [NIB_W-1:0]    nib_cnt_q, nib_cnt_d;
    logic [CNT_W-1:0]    word_count_q, word_count_d;
    logic [7:0]          err_count_q, err_count_d;
    logic                rx_clr_q, rx_clr_d;
    logic                tx_wr_q, tx_wr_d;
    logic [7:0]          tx_data_q, tx_data_d;
    logic                mem_we_q, mem_we_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [WORD_W-1:0]   mem_wdata_q, mem_wdata_d;

    logic                is_digit, is_hex, is_sep, is_restart, is_quit;
    logic [3:0]          nib;
    logic [7:0]          err_inc;
    logic                accept;
    logic                is_full;

    assign is_digit   = (rx_data >= 8'h30) && (rx_data <= 8'h39);
    assign is_hex     = is_digit ||
                        ((rx_data >= 8'h41) && (rx_data <= 8'h46)) ||
                        ((rx_data >= 8'h61) && (rx_data <= 8'h66));
    // Letters A-F/a-f share low nibbles 1..6, so +9 maps them to 10..15.
    assign nib        = is_digit ? rx_data[3:0] : rx_data[3:0] + 4'd9;
    assign is_sep     = (rx_data == 8'h20) || (rx_data == 8'h0D) || (rx_data == 8'h0A);
    assign is_restart = (rx_data == 8'h52) || (rx_data == 8'h72);
    assign is_quit    = (rx_data == 8'h51) || (rx_data == 8'h71);

    assign err_inc    = (err_count_q == 8'hFF) ? err_count_q : err_count_q + 8'd1;
    assign is_full    = (word_count_q == DEPTH_CNT);
    // rx_valid is still high during the rx_clr cycle, so that cycle must not re-accept.
    assign accept     = rx_valid && !tx_busy && !rx_clr_q && (state_q != S_WRITE);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            acc_q        <= '0;
            nib_cnt_q    <= '0;
            word_count_q <= '0;
            err_count_q  <= '0;
            rx_clr_q     <= 1'b0;
            tx_wr_q      <= 1'b0;
            tx_data_q    <= '0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
        end else begin
            state_q      <= state_d;
            acc_q        <= acc_d;
            nib_cnt_q    <= nib_cnt_d;
            word_count_q <= word_count_d;
            err_count_q  <= err_count_d;
            rx_clr_q     <= rx_clr_d;
            tx_wr_q      <= tx_wr_d;
            tx_data_q    <= tx_data_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        acc_d        = acc_q;
        nib_cnt_d    = nib_cnt_q;
        word_count_d = word_count_q;
        err_count_d  = err_count_q;
        rx_clr_d     = 1'b0;
        tx_wr_d      = 1'b0;
        tx_data_d    = tx_data_q;
        mem_we_d     = 1'b0;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;

        if (state_q == S_WRITE) begin
            mem_we_d     = 1'b1;
            mem_addr_d   = word_count_q[ADDR_W-1:0];
            mem_wdata_d  = acc_q;
            word_count_d = word_count_q + CNT_W'(1);
            nib_cnt_d    = '0;
            state_d      = S_IDLE;
        end else if (accept) begin
            rx_clr_d  = 1'b1;
            tx_wr_d   = 1'b1;
            tx_data_d = rx_data;
            if (is_restart) begin
                word_count_d = '0;
                nib_cnt_d    = '0;
                acc_d        = '0;
                state_d      = S_IDLE;
            end else if (state_q == S_IDLE) begin
                if (is_hex) begin
                    acc_d = {acc_q[WORD_W-5:0], nib};
                    if (nib_cnt_q != LAST_NIB) begin
                        nib_cnt_d = nib_cnt_q + NIB_W'(1);
                    end else if (is_full) begin
                        err_count_d = err_inc;
                        nib_cnt_d   = '0;
                        acc_d       = '0;
                    end else begin
                        state_d = S_WRITE;
                    end
                end else if (is_sep) begin
                    if (nib_cnt_q != '0) begin
                        err_count_d = err_inc;
                        nib_cnt_d   = '0;
                        acc_d       = '0;
                    end
                end else if (is_quit) begin
                    nib_cnt_d = '0;
                    acc_d     = '0;
                    state_d   = S_DONE;
                end else begin
                    err_count_d = err_inc;
                    nib_cnt_d   = '0;
                    acc_d       = '0;
                end
            end
        end
    end

    assign rx_clr     = rx_clr_q;
    assign tx_wr      = tx_wr_q;
    assign tx_data    = tx_data_q;
    assign mem_we     = mem_we_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;
    assign word_count = word_count_q;
    assign full       = is_full;
    assign err_count  = err_count_q;
    assign load_done  = (state_q == S_DONE);

endmodule

`default_nettype wire
